enc_16_4_arbiter: RTL and testbench



---
 rtl/enc_16_4_arbiter.sv | 130 +++++++++++++
 tb/tb_enc_16_4_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/enc_16_4_arbiter.sv
// Sequential 16-to-4 request encoder with valid/ack handshake and merge counter.
// Define ROUND_ROBIN_EN for round-robin selection; the default build is fixed lowest-index priority.
module enc_16_4_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pending,
    output logic [7:0]  merge_count
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic [7:0]  merge_q, merge_d;
    logic [15:0] clr, rem;
    logic [3:0]  sel_idx;

    assign clr       = (valid_q && ack) ? (16'h0001 << code_q) : 16'h0000;
    assign rem       = pending_q & ~clr;
    assign pending_d = rem | req;

    always_comb begin
        merge_d = merge_q;
        if (((req & rem) != 16'h0000) && (merge_q != 8'hFF)) begin
            merge_d = merge_q + 8'd1;
        end
    end

    // In IDLE nothing is presented, so clr is zero and rem equals pending_q.
`ifdef ROUND_ROBIN_EN
    logic [3:0] last_q, last_d;
    logic [3:0] rr_idx;
    logic       sel_hit;

    always_comb begin
        sel_idx = 4'd0;
        sel_hit = 1'b0;
        rr_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            rr_idx = last_q + 4'd1 + 4'(i);
            if (!sel_hit && rem[rr_idx]) begin
                sel_idx = rr_idx;
                sel_hit = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rem[i]) begin
                sel_idx = 4'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
`ifdef ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (pending_q != 16'h0000) begin
                    code_d  = sel_idx;
                    valid_d = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (ack) begin
`ifdef ROUND_ROBIN_EN
                    last_d = code_q;
`endif
                    if (rem != 16'h0000) begin
                        code_d = sel_idx;
                    end else begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pending_q <= 16'h0000;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            merge_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            merge_q   <= merge_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= 4'hF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign code        = code_q;
    assign valid       = valid_q;
    assign pending     = pending_q;
    assign merge_count = merge_q;

endmodule

// File: tb/tb_enc_16_4_arbiter.sv
// Bench for enc_16_4_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_enc_16_4_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] req   = 16'h0000;
    logic        ack   = 1'b0;
    logic [3:0]  code;
    logic        valid;
    logic [15:0] pending;
    logic [7:0]  merge_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit [15:0] m_pend;
    int        m_code;
    bit        m_valid;
    int        m_merge;
    int        m_last;

    enc_16_4_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .code        (code),
        .valid       (valid),
        .pending     (pending),
        .merge_count (merge_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int msel(input bit [15:0] v);
        int start;
`ifdef ROUND_ROBIN_EN
        start = (m_last + 1) % 16;
`else
        start = 0;
`endif
        for (int k = 0; k < 16; k++) begin
            if (v[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = 16'h0000;
        m_code  = 0;
        m_valid = 1'b0;
        m_merge = 0;
        m_last  = 15;
    endtask

    task automatic model_edge(input bit [15:0] r, input bit a);
        bit [15:0] rem;
        rem = m_pend;
        if (m_valid && a) rem[m_code] = 1'b0;
        if ((r & rem) != 0 && m_merge < 255) m_merge = m_merge + 1;
        if (!m_valid) begin
            if (m_pend != 0) begin
                m_code  = msel(m_pend);
                m_valid = 1'b1;
            end
        end else if (a) begin
            m_last = m_code;
            if (rem != 0) m_code = msel(rem);
            else m_valid = 1'b0;
        end
        m_pend = rem | r;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".code"}, 32'(code), 32'(m_code));
        check({tag, ".pending"}, 32'(pending), 32'(m_pend));
        check({tag, ".merge"}, 32'(merge_count), 32'(m_merge));
    endtask

    // Drive inputs just after an edge, clock once, then compare against the model.
    task automatic cycle(input logic [15:0] r, input logic a, input string tag);
        req = r;
        ack = a;
        @(posedge clock);
        model_edge(r, a);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        req   = 16'hFFFF;
        reset = 1'b0;
        model_reset();
        #1;
        check_model("rst_async");
        repeat (2) @(posedge clock);
        #1;
        check_model("rst_hold");
        req   = 16'h0000;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clock);
        #1;
        do_reset();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        cycle(16'h0000, 1'b0, "rst_release");
        check("rst_rel_valid", 32'(valid), 32'd0);

        // Single request: two-edge latency, then one ack empties everything
        cycle(16'h0020, 1'b0, "single_a");
        check("single_lat1_valid", 32'(valid), 32'd0);
        cycle(16'h0000, 1'b0, "single_b");
        check("single_valid", 32'(valid), 32'd1);
        check("single_code", 32'(code), 32'd5);
        cycle(16'h0000, 1'b1, "single_ack");
        check("single_done_valid", 32'(valid), 32'd0);
        check("single_done_pend", 32'(pending), 32'd0);

        // Simultaneous requests with ack held
        do_reset();
        cycle(16'h8001, 1'b1, "simul_a");
        cycle(16'h0000, 1'b1, "simul_b");
        check("simul_code0", 32'(code), 32'd0);
        cycle(16'h0000, 1'b1, "simul_c");
        check("simul_code15", 32'(code), 32'd15);
        cycle(16'h0000, 1'b1, "simul_d");
        check("simul_idle", 32'(valid), 32'd0);

        // Two lines requesting every cycle with ack held
        do_reset();
        for (int i = 0; i < 8; i++) cycle(16'h0088, 1'b1, "fair");

        // Merges and saturation
        do_reset();
        cycle(16'h0004, 1'b0, "merge_p1");
        cycle(16'h0000, 1'b0, "merge_g1");
        cycle(16'h0004, 1'b0, "merge_p2");
        cycle(16'h0000, 1'b0, "merge_g2");
        cycle(16'h0004, 1'b0, "merge_p3");
        check("merge_count2", 32'(merge_count), 32'd2);
        check("merge_code", 32'(code), 32'd2);
        check("merge_valid", 32'(valid), 32'd1);
        cycle(16'h0000, 1'b1, "merge_ack");
        check("merge_ack_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 300; i++) cycle(16'h0004, 1'b0, "sat");
        check("merge_sat", 32'(merge_count), 32'd255);

        // Asynchronous reset while a grant is presented
        do_reset();
        cycle(16'h0A00, 1'b0, "mid_a");
        cycle(16'h0000, 1'b0, "mid_b");
        check("mid_code9", 32'(code), 32'd9);
        check("mid_pend", 32'(pending), 32'h0A00);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_code", 32'(code), 32'd0);
        check("mid_rst_pend", 32'(pending), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle(16'h0000, 1'b0, "mid_after");
        check("mid_after_valid", 32'(valid), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle(16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
